spi_slave: RTL and testbench

- SPI mode 3 slave: the far end of the team's 10-bit SPI master. SCK idles high; data changes on the SCK falling edge and is sampled on the SCK rising edge.
- Fully synchronous to the local clk. SS, SCK and DIN are oversampled through synchronizers, and SCK edges are detected in the clk domain.
- Captures one WIDTH-bit word from the master per frame and returns a locally supplied word. Bit order is LSB-first or MSB-first, selected by mlb.

---
 rtl/spi_slave.sv | 175 +++++++++++++++++
 tb/tb_spi_slave.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode 3 slave (SCK idles high, drive on fall, sample on rise), oversampled in the clk domain.
// Exchanges one WIDTH-bit word per ss-low frame, LSB- or MSB-first as selected by mlb.
module spi_slave #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             mlb,
  input  logic [WIDTH-1:0] tdat,
  input  logic             ss,
  input  logic             sck,
  input  logic             din,
  output logic             dout,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             abort
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FINISH = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       treg_q, treg_d;
  logic [WIDTH-1:0]       rreg_q, rreg_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   abort_q, abort_d;

  logic             ss_s, sck_s, din_s;
  logic             rise_s, fall_s, ss_fall_s, last_bit_s;
  logic [CW-1:0]    cnt_inc_s;
  logic [WIDTH-1:0] rreg_shift_s, treg_shift_s;

  assign ss_s  = ss_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];

  assign rise_s     = ~sck_prev_q & sck_s;
  assign fall_s     = sck_prev_q & ~sck_s;
  assign ss_fall_s  = ss_prev_q & ~ss_s;
  assign cnt_inc_s  = cnt_q + CW'(1);
  assign last_bit_s = rise_s && (cnt_inc_s == CW'(WIDTH));

  assign rreg_shift_s = mlb ? {rreg_q[WIDTH-2:0], din_s} : {din_s, rreg_q[WIDTH-1:1]};
  assign treg_shift_s = mlb ? {treg_q[WIDTH-2:0], 1'b1}  : {1'b1, treg_q[WIDTH-1:1]};

  always_comb begin
    ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], din};
    ss_prev_d  = ss_s;
    sck_prev_d = sck_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    treg_d     = treg_q;
    rreg_d     = rreg_q;
    rdata_d    = rdata_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      IDLE: begin
        dout_d = 1'b1;
        if (ss_fall_s) begin
          treg_d  = tdat;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = ACTIVE;
        end else begin
          busy_d = 1'b0;
        end
      end
      ACTIVE: begin
        // Completion outranks a simultaneous deselect, so it is tested first.
        if (last_bit_s) begin
          rreg_d  = rreg_shift_s;
          rdata_d = rreg_shift_s;
          cnt_d   = cnt_inc_s;
          done_d  = 1'b1;
          dout_d  = 1'b1;
          if (ss_s) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = FINISH;
          end
        end else if (ss_s) begin
          abort_d = 1'b1;
          dout_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (rise_s) begin
          rreg_d = rreg_shift_s;
          cnt_d  = cnt_inc_s;
        end else if (fall_s) begin
          if (cnt_q == {CW{1'b0}}) begin
            dout_d = mlb ? treg_q[WIDTH-1] : treg_q[0];
          end else begin
            treg_d = treg_shift_s;
            dout_d = mlb ? treg_shift_s[WIDTH-1] : treg_shift_s[0];
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      FINISH: begin
        dout_d = 1'b1;
        if (ss_s) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = FINISH;
        end
      end
      default: begin
        dout_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Synchronizers preset to the idle line levels so reset release creates no false edges.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ss_sync_q  <= {SYNC_STAGES{1'b1}};
      sck_sync_q <= {SYNC_STAGES{1'b1}};
      din_sync_q <= {SYNC_STAGES{1'b1}};
      ss_prev_q  <= 1'b1;
      sck_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      treg_q     <= {WIDTH{1'b1}};
      rreg_q     <= {WIDTH{1'b1}};
      rdata_q    <= {WIDTH{1'b0}};
      dout_q     <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      ss_sync_q  <= ss_sync_d;
      sck_sync_q <= sck_sync_d;
      din_sync_q <= din_sync_d;
      ss_prev_q  <= ss_prev_d;
      sck_prev_q <= sck_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      treg_q     <= treg_d;
      rreg_q     <= rreg_d;
      rdata_q    <= rdata_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

  assign dout  = dout_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign abort = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of whole frames plus a hand-written mid-frame reset sequence.
// The bench plays the SPI master with an SCK period of 16 clk.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       mlb = 1'b0;
  logic [9:0] tdat = 10'h000;
  logic       ss = 1'b1;
  logic       sck = 1'b1;
  logic       din = 1'b1;
  logic       dout, done, busy, abort;
  logic [9:0] rdata;

  int n_vec = 0;
  int n_bad = 0;
  int done_total = 0;
  int abort_total = 0;

  typedef struct {
    logic       mlb;
    logic [9:0] tdat;
    logic [9:0] tx;
    int         ncyc;
    int         gap;
    logic [9:0] exp_rdata;
    logic [9:0] exp_seq;
    int         exp_done;
    int         exp_abort;
  } vec_t;

  vec_t vt[6];

  spi_slave #(.WIDTH(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstb(rstb), .mlb(mlb), .tdat(tdat), .ss(ss), .sck(sck), .din(din),
    .dout(dout), .done(done), .rdata(rdata), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  // Count clk cycles during which done / abort are high.
  always @(negedge clk) begin
    if (done)  done_total  <= done_total + 1;
    if (abort) abort_total <= abort_total + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int          d0;
    int          a0;
    int          nb;
    logic [15:0] got;
    logic        busy_mid;
    logic [9:0]  mask;
    d0       = done_total;
    a0       = abort_total;
    got      = 16'h0000;
    busy_mid = 1'b0;
    mlb      = v.mlb;
    tdat     = v.tdat;
    ss       = 1'b0;
    wait_clk(6);
    tdat = ~v.tdat;
    for (int i = 0; i < v.ncyc; i++) begin
      sck = 1'b0;
      din = (i < 10) ? (v.mlb ? v.tx[9-i] : v.tx[i]) : 1'b0;
      wait_clk(8);
      got[i] = dout;
      if (i == 0) busy_mid = busy;
      sck = 1'b1;
      wait_clk(8);
    end
    wait_clk(8);
    ss = 1'b1;
    din = 1'b1;
    wait_clk(v.gap);
    nb   = (v.ncyc < 10) ? v.ncyc : 10;
    mask = 10'((32'h1 << nb) - 32'h1);
    chk({tag, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
    chk({tag, " done_cycles"}, 32'(done_total - d0), 32'(v.exp_done));
    chk({tag, " abort_cycles"}, 32'(abort_total - a0), 32'(v.exp_abort));
    chk({tag, " dout_seq"}, 32'(got[9:0] & mask), 32'(v.exp_seq & mask));
    chk({tag, " busy_mid"}, 32'(busy_mid), 32'h1);
    chk({tag, " busy_after"}, 32'(busy), 32'h0);
    chk({tag, " dout_idle"}, 32'(dout), 32'h1);
    if (v.ncyc > 10) chk({tag, " dout_extra"}, 32'(got[11:10]), 32'h3);
  endtask

  initial begin
    int d0;
    int a0;
    vt[0] = '{1'b0, 10'h2A5, 10'h15A, 10, 8, 10'h15A, 10'h2A5, 1, 0};
    vt[1] = '{1'b1, 10'h301, 10'h0F3, 10, 8, 10'h0F3, 10'h203, 1, 0};
    vt[2] = '{1'b0, 10'h0C3, 10'h3FF, 10, 4, 10'h3FF, 10'h0C3, 1, 0};
    vt[3] = '{1'b0, 10'h35A, 10'h000, 10, 8, 10'h000, 10'h35A, 1, 0};
    vt[4] = '{1'b0, 10'h2A5, 10'h3FF, 6,  8, 10'h000, 10'h2A5, 0, 1};
    vt[5] = '{1'b0, 10'h1E7, 10'h155, 12, 8, 10'h155, 10'h1E7, 1, 0};

    wait_clk(3);
    chk("reset dout", 32'(dout), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset abort", 32'(abort), 32'h0);
    chk("reset rdata", 32'(rdata), 32'h0);
    rstb = 1'b1;
    wait_clk(4);

    for (int k = 0; k < 6; k++) run_frame(vt[k], $sformatf("vec%0d", k));

    // Reset in the middle of a frame, after five bits.
    d0   = done_total;
    a0   = abort_total;
    mlb  = 1'b0;
    tdat = 10'h2A5;
    ss   = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 5; i++) begin
      sck = 1'b0;
      din = 1'b1;
      wait_clk(8);
      sck = 1'b1;
      wait_clk(8);
    end
    sck = 1'b0;
    wait_clk(4);
    rstb = 1'b0;
    #1;
    chk("midrst dout", 32'(dout), 32'h1);
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst rdata", 32'(rdata), 32'h0);
    wait_clk(2);
    ss  = 1'b1;
    sck = 1'b1;
    wait_clk(2);
    rstb = 1'b1;
    wait_clk(8);
    chk("midrst done_cycles", 32'(done_total - d0), 32'h0);
    chk("midrst abort_cycles", 32'(abort_total - a0), 32'h0);
    run_frame('{1'b0, 10'h0F0, 10'h0AA, 10, 8, 10'h0AA, 10'h0F0, 1, 0}, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
